// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers for the pipelined mux tree.
// Functions: clog2, n_stg, sel_left, stg_lanes.
package mux_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int n_stg(input int sel_w, input int lps);
    return (sel_w + lps - 1) / lps;
  endfunction

  // select bits still unresolved after stage s
  function automatic int sel_left(input int sel_w, input int lps,
                                  input int s);
    int r;
    r = sel_w - lps * (s + 1);
    return (r < 0) ? 0 : r;
  endfunction

  // lanes held in the register of stage s (never below 1)
  function automatic int stg_lanes(input int n_in, input int lps,
                                   input int s);
    return 1 << sel_left(clog2(n_in), lps, s);
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One pipeline stage of the mux tree: radix-2^k mux + registers.
// Ports: src_* upstream beat, ready/valid handshake, data/sel/frc regs.
module mux_tree_stage
  import mux_tree_pkg::*;
#(
  parameter  int N_IN        = 16,
  parameter  int DATA_W      = 1,
  parameter  int LVL_PER_STG = 2,
  parameter  int STG         = 0,
  localparam int SEL_W = clog2(N_IN),
  localparam int RIN   = SEL_W - STG * LVL_PER_STG,
  localparam int ROUT  = sel_left(SEL_W, LVL_PER_STG, STG),
  localparam int RB    = RIN - ROUT,
  localparam int IL    = 1 << RIN,
  localparam int OL    = 1 << ROUT,
  localparam int SO_W  = (ROUT > 0) ? ROUT : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               src_valid,
  input  logic [IL*DATA_W-1:0] src_data,
  input  logic [RIN-1:0]     src_sel,
  input  logic               src_frc,
  output logic               ready,
  output logic               valid,
  input  logic               nxt_ready,
  output logic [OL*DATA_W-1:0] data,
  output logic [SO_W-1:0]    sel,
  output logic               frc
);

  localparam int RADIX = 1 << RB;

  logic [OL*DATA_W-1:0] mux;
  logic [SO_W-1:0]      sel_nxt;
  logic                 load;

  always_comb begin
    mux = '0;
    for (int j = 0; j < OL; j++)
      mux[j*DATA_W +: DATA_W] =
        src_data[(j*RADIX + int'(src_sel[RB-1:0]))*DATA_W +: DATA_W];
  end

  if (ROUT > 0) begin : g_up
    assign sel_nxt = src_sel[RIN-1:RB];
  end else begin : g_none
    assign sel_nxt = '0;
  end

  assign ready = ~valid | nxt_ready;
  assign load  = src_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      sel   <= '0;
      frc   <= 1'b0;
    end else begin
      if (ready) valid <= src_valid;
      // registers only move on a transfer
      if (load) begin
        data <= mux;
        sel  <= sel_nxt;
        frc  <= src_frc;
      end
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 lane mux with force-to-ones and optional invert.
// Ports: in_valid/in_ready, din, sel, frc; out_valid/out_ready, dout.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int N_IN        = 16,
  parameter  int DATA_W      = 1,
  parameter  int LVL_PER_STG = 2,
  parameter  int INVERT      = 0,
  localparam int SEL_W = clog2(N_IN),
  localparam int N_STG = n_stg(SEL_W, LVL_PER_STG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   frc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      dout
);

  logic [N_STG:0] vld;
  logic [N_STG:0] rdy;

  assign vld[0]     = in_valid;
  assign in_ready   = rdy[0];
  assign rdy[N_STG] = out_ready;
  assign out_valid  = vld[N_STG];

  for (genvar s = 0; s < N_STG; s++) begin : g_stg
    localparam int RIN  = SEL_W - s * LVL_PER_STG;
    localparam int IL   = 1 << RIN;
    localparam int OL   = stg_lanes(N_IN, LVL_PER_STG, s);
    localparam int LEFT = sel_left(SEL_W, LVL_PER_STG, s);
    localparam int SO_W = (LEFT > 0) ? LEFT : 1;

    logic [IL*DATA_W-1:0] src_data;
    logic [RIN-1:0]       src_sel;
    logic                 src_frc;
    logic [OL*DATA_W-1:0] st_data;
    logic [SO_W-1:0]      st_sel;
    logic                 st_frc;

    if (s == 0) begin : g_head
      assign src_data = din;
      assign src_sel  = sel;
      assign src_frc  = frc;
    end else begin : g_link
      assign src_data = g_stg[s-1].st_data;
      assign src_sel  = g_stg[s-1].st_sel;
      assign src_frc  = g_stg[s-1].st_frc;
    end

    mux_tree_stage #(
      .N_IN        (N_IN),
      .DATA_W      (DATA_W),
      .LVL_PER_STG (LVL_PER_STG),
      .STG         (s)
    ) u_stg (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (vld[s]),
      .src_data  (src_data),
      .src_sel   (src_sel),
      .src_frc   (src_frc),
      .ready     (rdy[s]),
      .valid     (vld[s+1]),
      .nxt_ready (rdy[s+1]),
      .data      (st_data),
      .sel       (st_sel),
      .frc       (st_frc)
    );
  end

  logic [DATA_W-1:0] res;
  logic              res_frc;
  logic              unused_sel;

  assign res        = g_stg[N_STG-1].st_data;
  assign res_frc    = g_stg[N_STG-1].st_frc;
  assign unused_sel = ^g_stg[N_STG-1].st_sel;

  // gated by out_valid so an empty pipe reads 0 even with INVERT
  always_comb begin
    dout = '0;
    if (out_valid) begin
      if (res_frc)          dout = '1;
      else if (INVERT != 0) dout = ~res;
      else                  dout = res;
    end
  end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe in three configurations.
// A: 16x1 lps2, B: 8x4 lps2 invert, C: 16x8 lps4.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_frc, a_out_valid, a_out_ready;
  logic [15:0] a_din;
  logic [3:0]  a_sel;
  logic [0:0]  a_dout;

  logic        b_in_valid, b_in_ready, b_frc, b_out_valid, b_out_ready;
  logic [31:0] b_din;
  logic [2:0]  b_sel;
  logic [3:0]  b_dout;

  logic         c_in_valid, c_in_ready, c_frc, c_out_valid, c_out_ready;
  logic [127:0] c_din;
  logic [3:0]   c_sel;
  logic [7:0]   c_dout;

  logic       qa[$];
  logic [3:0] qb[$];
  logic [7:0] qc[$];

  int errors = 0;
  int checks = 0;

  mux_tree_pipe #(.N_IN(16), .DATA_W(1), .LVL_PER_STG(2), .INVERT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .din(a_din), .sel(a_sel), .frc(a_frc), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .dout(a_dout));

  mux_tree_pipe #(.N_IN(8), .DATA_W(4), .LVL_PER_STG(2), .INVERT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .din(b_din), .sel(b_sel), .frc(b_frc), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .dout(b_dout));

  mux_tree_pipe #(.N_IN(16), .DATA_W(8), .LVL_PER_STG(4), .INVERT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .din(c_din), .sel(c_sel), .frc(c_frc), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .dout(c_dout));

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_din = '0; a_sel = '0; a_frc = 0; a_out_ready = 1;
    b_in_valid = 0; b_din = '0; b_sel = '0; b_frc = 0; b_out_ready = 1;
    c_in_valid = 0; c_din = '0; c_sel = '0; c_frc = 0; c_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid);
    end
    checks++;
    if (a_dout !== 1'b0) begin
      errors++; $display("FAIL reset_a_dout: got %b want 0", a_dout);
    end
    checks++;
    if (b_dout !== 4'h0) begin
      errors++; $display("FAIL reset_b_dout: got %h want 0", b_dout);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_a_ready: got %b want 1", a_in_ready);
    end
    checks++;
    if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_c: ready %b valid %b want 1 0",
               c_in_ready, c_out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_walk();
    logic [15:0] pat;
    logic        e;
    int sent = 0, got = 0, cyc = 0, acc0 = -1, out0 = -1;
    pat = 16'hA5C3;
    a_out_ready = 1;
    while ((sent < 16 || qa.size() > 0) && cyc < 60) begin
      a_in_valid = (sent < 16);
      a_din = pat; a_sel = sent[3:0]; a_frc = 0;
      #1;
      if (a_out_valid && a_out_ready) begin
        if (out0 < 0) out0 = cyc;
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL walk_extra: got %b want none", a_dout);
        end else begin
          e = qa.pop_front();
          if (a_dout !== e) begin
            errors++; $display("FAIL walk_dout%0d: got %b want %b", got, a_dout, e);
          end
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        if (acc0 < 0) acc0 = cyc;
        qa.push_back(pat[sent]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_in_valid = 0;
    checks++;
    if (got != 16 || qa.size() != 0) begin
      errors++; $display("FAIL walk_count: got %0d want 16", got);
    end
    checks++;
    if (out0 - acc0 != 2) begin
      errors++; $display("FAIL walk_latency: got %0d want 2", out0 - acc0);
    end
  endtask

  task automatic test_force();
    int cyc = 0, got = 0;
    logic       ea;
    logic [7:0] ec;
    a_out_ready = 1; c_out_ready = 1;
    while (cyc < 10 && got == 0) begin
      a_in_valid = (cyc == 0); a_din = 16'h0000; a_sel = 4'd7; a_frc = 1;
      #1;
      if (a_in_valid && a_in_ready)
        qa.push_back(a_frc ? 1'b1 : a_din[a_sel]);
      if (a_out_valid) begin
        got++;
        ea = (qa.size() > 0) ? qa.pop_front() : 1'b0;
        checks++;
        if (a_dout !== ea) begin
          errors++; $display("FAIL force_a: got %b want %b", a_dout, ea);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_in_valid = 0; a_frc = 0;
    checks++;
    if (got != 1) begin
      errors++; $display("FAIL force_a_seen: got %0d want 1", got);
    end
    cyc = 0; got = 0;
    while (cyc < 10 && got == 0) begin
      c_in_valid = (cyc == 0); c_din = '0; c_sel = 4'd2; c_frc = 1;
      #1;
      if (c_in_valid && c_in_ready)
        qc.push_back(c_frc ? 8'hFF : c_din[c_sel*8 +: 8]);
      if (c_out_valid) begin
        got++;
        ec = (qc.size() > 0) ? qc.pop_front() : 8'h00;
        checks++;
        if (c_dout !== ec) begin
          errors++; $display("FAIL force_c: got %h want %h", c_dout, ec);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    c_in_valid = 0; c_frc = 0;
    checks++;
    if (got != 1) begin
      errors++; $display("FAIL force_c_seen: got %0d want 1", got);
    end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, cyc = 0;
    logic [3:0] sels[4];
    logic       e;
    sels = '{4'd0, 4'd2, 4'd6, 4'd3};
    a_din = 16'hA5C3; a_frc = 0;
    while ((sent < 4 || qa.size() > 0) && cyc < 40) begin
      a_out_ready = (cyc < 2) || (cyc >= 8);
      a_in_valid = (sent < 4);
      a_sel = sels[sent % 4];
      #1;
      if (cyc >= 2 && cyc < 8) begin
        checks++;
        if (a_in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL stall_ready c%0d: ready %b sent %0d want 0 2",
                   cyc, a_in_ready, sent);
        end
        checks++;
        if (a_out_valid !== 1'b1 || qa.size() == 0 || a_dout !== qa[0]) begin
          errors++;
          $display("FAIL stall_hold c%0d: valid %b dout %b want 1 %b",
                   cyc, a_out_valid, a_dout, (qa.size() > 0) ? qa[0] : 1'bx);
        end
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL stall_extra: got %b want none", a_dout);
        end else begin
          e = qa.pop_front();
          if (a_dout !== e) begin
            errors++; $display("FAIL stall_dout%0d: got %b want %b", got, a_dout, e);
          end
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        qa.push_back(a_din[a_sel]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_in_valid = 0; a_out_ready = 1;
    checks++;
    if (got != 4 || qa.size() != 0) begin
      errors++; $display("FAIL stall_count: got %0d want 4", got);
    end
  endtask

  task automatic test_invert();
    int cyc = 0, acc = -1, out = -1;
    logic [3:0] e;
    b_din = {$urandom};
    b_din[5*4 +: 4] = 4'h3;
    b_sel = 3'd5; b_frc = 0; b_out_ready = 1;
    while (cyc < 10 && out < 0) begin
      b_in_valid = (cyc == 0);
      #1;
      if (b_in_valid && b_in_ready) begin
        acc = cyc;
        qb.push_back(~b_din[b_sel*4 +: 4]);
      end
      if (b_out_valid) begin
        out = cyc;
        e = (qb.size() > 0) ? qb.pop_front() : 4'hx;
        checks++;
        if (b_dout !== e) begin
          errors++; $display("FAIL invert_dout: got %h want %h", b_dout, e);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    b_in_valid = 0;
    checks++;
    if (acc < 0 || out - acc != 2) begin
      errors++; $display("FAIL invert_latency: got %0d want 2", out - acc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, acc = -1, out = -1;
    logic e;
    a_out_ready = 1; a_frc = 0; a_din = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1; a_sel = i[3:0];
      #1;
      if (a_in_ready) qa.push_back(a_din[a_sel]);
      @(posedge clk); #1;
    end
    a_in_valid = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_dout !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid %b dout %b want 0 0",
               a_out_valid, a_dout);
    end
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_din = 16'h0020;
    a_sel = 4'd5;
    while (cyc < 10 && out < 0) begin
      a_in_valid = (cyc == 0);
      #1;
      if (a_out_valid) begin
        out = cyc;
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL rstmid_stale: got %b want none", a_dout);
        end else begin
          e = qa.pop_front();
          if (a_dout !== e) begin
            errors++; $display("FAIL rstmid_dout: got %b want %b", a_dout, e);
          end
        end
      end
      if (a_in_valid && a_in_ready) begin
        acc = cyc;
        qa.push_back(a_din[a_sel]);
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_in_valid = 0;
    checks++;
    if (acc < 0 || out - acc != 2) begin
      errors++; $display("FAIL rstmid_latency: got %0d want 2", out - acc);
    end
    qa.delete();
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0, acc = -1, out = -1;
    bit fire = 1'b0;
    logic [7:0] e;
    c_out_ready = 1; c_frc = 0;
    c_din = {$urandom, $urandom, $urandom, $urandom};
    c_sel = 4'd15;
    while (cyc < 10 && out < 0) begin
      c_in_valid = (cyc == 0);
      #1;
      if (c_out_valid) begin
        out = cyc;
        e = (qc.size() > 0) ? qc.pop_front() : 8'hxx;
        checks++;
        if (c_dout !== e) begin
          errors++; $display("FAIL lat1_dout: got %h want %h", c_dout, e);
        end
      end
      if (c_in_valid && c_in_ready) begin
        acc = cyc;
        qc.push_back(c_din[c_sel*8 +: 8]);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (acc < 0 || out - acc != 1) begin
      errors++; $display("FAIL lat1_latency: got %0d want 1", out - acc);
    end
    c_in_valid = 0;
    cyc = 0;
    while ((sent < 10000 || qc.size() > 0) && cyc < 40000) begin
      if (!c_in_valid || fire) begin
        c_in_valid = (sent < 10000) && ($urandom_range(3) != 0);
        c_din = {$urandom, $urandom, $urandom, $urandom};
        c_sel = 4'($urandom_range(15));
        c_frc = ($urandom_range(7) == 0);
      end
      c_out_ready = ($urandom_range(9) < 7);
      #1;
      if (c_out_valid && c_out_ready) begin
        checks++;
        if (qc.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %h want none", c_dout);
        end else begin
          e = qc.pop_front();
          if (c_dout !== e) begin
            errors++; $display("FAIL rand_dout%0d: got %h want %h", got, c_dout, e);
          end
        end
        got++;
      end
      fire = c_in_valid && c_in_ready;
      if (fire) begin
        qc.push_back(c_frc ? 8'hFF : c_din[c_sel*8 +: 8]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    c_in_valid = 0; c_out_ready = 1;
    checks++;
    if (got != 10000 || qc.size() != 0) begin
      errors++; $display("FAIL rand_count: got %0d want 10000", got);
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_force();
    test_stall();
    test_invert();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
